// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: synchronizes and debounces two buttons, runs IDLE/RUNNING/PAUSED/HALTED, emits inc/clr pulses.
// A clean press reaches the FSM DEBOUNCE_CYCLES+2 edges after first sampled high; all outputs are registered.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic at_max,
  output logic inc,
  output logic clr,
  output logic running,
  output logic overflow
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Bit 0 carries start/stop, bit 1 carries clear.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d, deb_dly_q;
  logic [1:0][DB_W-1:0]  dcnt_q, dcnt_d;
  logic [1:0]            press;

  logic [1:0]      state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            inc_q, inc_d, clr_q, clr_d;
  logic            running_q, overflow_q;
  logic            wrap;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_MAX) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;
  assign wrap  = (state_q == S_RUN) && (presc_q == PS_MAX);

  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    if (press[1]) begin
      state_d = S_IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  if (press[0]) state_d = S_RUN;
        S_RUN: begin
          // A pause landing on the wrap edge defers the tick until resume.
          if (wrap && at_max)  state_d = S_HALT;
          else if (press[0])   state_d = S_PAUSE;
          else if (wrap)       inc_d   = 1'b1;
        end
        S_PAUSE: if (press[0]) state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Counting only while staying in RUN keeps the partial tick intact across a pause.
  always_comb begin
    presc_d = '0;
    if (state_d == S_RUN && state_q == S_RUN) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end else if (state_d == S_RUN || state_d == S_PAUSE) begin
      presc_d = presc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      dcnt_q     <= '0;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      inc_q      <= 1'b0;
      clr_q      <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= {btn_clear, btn_start_stop};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      dcnt_q     <= dcnt_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      inc_q      <= inc_d;
      clr_q      <= clr_d;
      running_q  <= (state_d == S_RUN);
      overflow_q <= (state_d == S_HALT);
    end
  end

  assign inc      = inc_q;
  assign clr      = clr_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10; edges are numbered continuously across tasks.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset, btn_start_stop, btn_clear, at_max;
  logic inc, clr, running, overflow;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(10)) dut (
    .clk(clk), .reset(reset), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .at_max(at_max), .inc(inc), .clr(clr), .running(running), .overflow(overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    reset = 1'b1; btn_start_stop = 1'b0; btn_clear = 1'b0; at_max = 1'b0;
    #12;
    got = {inc, clr, running, overflow};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got inc/clr/run/ovf=%b expected 0000", got);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      got = {inc, clr, running, overflow};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet cyc=%0d got %b expected 0000", i, got);
      end
    end
  endtask

  // Press edges 0..9: event at edge 6, inc at 16/26/36.
  task automatic test_start;
    logic [3:0] got, exp;
    for (int e = 0; e < 40; e++) begin
      btn_start_stop = (e < 10);
      tick();
      got = {inc, clr, running, overflow};
      exp = {(e == 16 || e == 26 || e == 36), 1'b0, (e >= 6), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL start e=%0d got inc/clr/run/ovf=%b expected %b", e, got, exp);
      end
    end
  endtask

  // Pause lands at edge 50 with prescaler at 3; resume at 66, first inc at 73.
  task automatic test_pause_resume;
    logic [3:0] got, exp;
    for (int e = 40; e < 86; e++) begin
      btn_start_stop = (e >= 44 && e < 50) || (e >= 60 && e < 66);
      tick();
      got = {inc, clr, running, overflow};
      exp = {(e == 46 || e == 73 || e == 83), 1'b0, (e < 50 || e >= 66), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pause_resume e=%0d got inc/clr/run/ovf=%b expected %b", e, got, exp);
      end
    end
  endtask

  // Wrap at edge 93 with at_max halts; start/stop ignored; clear event at 117.
  task automatic test_halt;
    logic [3:0] got, exp;
    for (int e = 86; e < 126; e++) begin
      at_max         = (e < 118);
      btn_start_stop = (e >= 96 && e < 102);
      btn_clear      = (e >= 111 && e < 117);
      tick();
      got = {inc, clr, running, overflow};
      exp = {1'b0, (e == 117), (e < 93), (e >= 93 && e < 117)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL halt e=%0d got inc/clr/run/ovf=%b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] got;
    for (int e = 126; e < 150; e++) begin
      btn_start_stop = (e < 138) && ((((e - 126) / 2) % 2) == 0);
      tick();
      got = {inc, clr, running, overflow};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL bounce e=%0d got inc/clr/run/ovf=%b expected 0000", e, got);
      end
    end
  endtask

  // Run from 157; clear+start_stop both land on the wrap edge 177.
  task automatic test_simultaneous;
    logic [3:0] got, exp;
    for (int e = 150; e < 191; e++) begin
      btn_start_stop = (e >= 151 && e < 157) || (e >= 171 && e < 177);
      btn_clear      = (e >= 171 && e < 177);
      tick();
      got = {inc, clr, running, overflow};
      exp = {(e == 167), (e == 177), (e >= 157 && e < 177), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simultaneous e=%0d got inc/clr/run/ovf=%b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] got, exp;
    for (int e = 191; e < 208; e++) begin
      btn_start_stop = (e >= 191 && e < 197);
      tick();
      got = {inc, clr, running, overflow};
      exp = {(e == 207), 1'b0, (e >= 197), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rerun e=%0d got inc/clr/run/ovf=%b expected %b", e, got, exp);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    got = {inc, clr, running, overflow};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got inc/clr/run/ovf=%b expected 0000", got);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      got = {inc, clr, running, overflow};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got inc/clr/run/ovf=%b expected 0000", i, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_halt();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
